// File: rtl/ps2_game_input.sv
// ps2_game_input: PS/2 Set-2 keyboard front end for the shooter game.
// Conditions the raw PS/2 lines, captures 11-bit frames, decodes
// make/break sequences and drives the game controls.
//
// Ports:
//   clk, reset          - system clock, async active-high reset
//   ps2_clk, ps2_data   - raw keyboard lines (asynchronous, never driven)
//   ctrl_up/down/left/right, shooting - held-key levels
//   enter, bomb         - one-cycle pulses on first make of Enter / X
//   rx_byte, rx_valid   - last good byte and its one-cycle strobe
//   frame_err           - one-cycle pulse on parity/start/stop/timeout error
module ps2_game_input #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 200_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ctrl_up,
    output logic       ctrl_down,
    output logic       ctrl_left,
    output logic       ctrl_right,
    output logic       shooting,
    output logic       enter,
    output logic       bomb,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} dec_state_e;

    logic           clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic           dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic           filt_q, filt_d, filt_prev_q, filt_prev_d;
    logic [FW-1:0]  filt_cnt_q, filt_cnt_d;
    logic [10:0]    frame_q, frame_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]  wd_q, wd_d;
    logic [7:0]     rx_byte_q, rx_byte_d;
    logic           rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
    dec_state_e     state_q, state_d;
    logic           up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d;
    logic           shoot_q, shoot_d, enter_q, enter_d, bomb_q, bomb_d;
    logic           enter_held_q, enter_held_d, x_held_q, x_held_d;
    logic           fall;
    logic           key_ev, key_make, key_ext;

    always_comb begin
        clk_s1_d = ps2_clk;
        clk_s2_d = clk_s1_q;
        dat_s1_d = ps2_data;
        dat_s2_d = dat_s1_q;

        // Filtered level flips only after FILTER_LEN consecutive differing samples.
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
        filt_prev_d = filt_q;
        fall        = filt_prev_q & ~filt_q;

        frame_d     = frame_q;
        bit_cnt_d   = bit_cnt_q;
        wd_d        = wd_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        if (fall) begin
            // Shift in LSB-first: frame[0]=start, [8:1]=data, [9]=parity, [10]=stop.
            frame_d = {dat_s2_q, frame_q[10:1]};
            wd_d    = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = '0;
                if (!frame_d[0] && frame_d[10] && (^frame_d[9:1])) begin
                    rx_byte_d  = frame_d[8:1];
                    rx_valid_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            // Watchdog only runs mid-frame; an edge in the same cycle takes priority above.
            if (wd_q == TW'(TIMEOUT - 1)) begin
                bit_cnt_d   = '0;
                wd_d        = '0;
                frame_err_d = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end

        state_d      = state_q;
        up_d         = up_q;
        down_d       = down_q;
        left_d       = left_q;
        right_d      = right_q;
        shoot_d      = shoot_q;
        enter_held_d = enter_held_q;
        x_held_d     = x_held_q;
        enter_d      = 1'b0;
        bomb_d       = 1'b0;
        key_ev       = 1'b0;
        key_make     = 1'b0;
        key_ext      = 1'b0;
        if (rx_valid_q) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rx_byte_q == 8'hE0)      state_d = S_EXT;
                    else if (rx_byte_q == 8'hF0) state_d = S_BRK;
                    else begin
                        key_ev   = 1'b1;
                        key_make = 1'b1;
                    end
                end
                S_EXT: begin
                    if (rx_byte_q == 8'hF0) state_d = S_EXT_BRK;
                    else begin
                        key_ev   = 1'b1;
                        key_make = 1'b1;
                        key_ext  = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_BRK: begin
                    key_ev  = 1'b1;
                    state_d = S_IDLE;
                end
                S_EXT_BRK: begin
                    key_ev  = 1'b1;
                    key_ext = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end

        if (key_ev) begin
            if (key_ext) begin
                case (rx_byte_q)
                    8'h75:   up_d    = key_make;
                    8'h72:   down_d  = key_make;
                    8'h6B:   left_d  = key_make;
                    8'h74:   right_d = key_make;
                    default: ;
                endcase
            end else begin
                case (rx_byte_q)
                    8'h1A: shoot_d = key_make;
                    8'h5A: begin
                        enter_d      = key_make & ~enter_held_q;
                        enter_held_d = key_make;
                    end
                    8'h22: begin
                        bomb_d   = key_make & ~x_held_q;
                        x_held_d = key_make;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s2_q     <= 1'b1;
            filt_q       <= 1'b1;
            filt_prev_q  <= 1'b1;
            filt_cnt_q   <= '0;
            frame_q      <= '0;
            bit_cnt_q    <= '0;
            wd_q         <= '0;
            rx_byte_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            state_q      <= S_IDLE;
            up_q         <= 1'b0;
            down_q       <= 1'b0;
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            shoot_q      <= 1'b0;
            enter_q      <= 1'b0;
            bomb_q       <= 1'b0;
            enter_held_q <= 1'b0;
            x_held_q     <= 1'b0;
        end else begin
            clk_s1_q     <= clk_s1_d;
            clk_s2_q     <= clk_s2_d;
            dat_s1_q     <= dat_s1_d;
            dat_s2_q     <= dat_s2_d;
            filt_q       <= filt_d;
            filt_prev_q  <= filt_prev_d;
            filt_cnt_q   <= filt_cnt_d;
            frame_q      <= frame_d;
            bit_cnt_q    <= bit_cnt_d;
            wd_q         <= wd_d;
            rx_byte_q    <= rx_byte_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            state_q      <= state_d;
            up_q         <= up_d;
            down_q       <= down_d;
            left_q       <= left_d;
            right_q      <= right_d;
            shoot_q      <= shoot_d;
            enter_q      <= enter_d;
            bomb_q       <= bomb_d;
            enter_held_q <= enter_held_d;
            x_held_q     <= x_held_d;
        end
    end

    assign ctrl_up    = up_q;
    assign ctrl_down  = down_q;
    assign ctrl_left  = left_q;
    assign ctrl_right = right_q;
    assign shooting   = shoot_q;
    assign enter      = enter_q;
    assign bomb       = bomb_q;
    assign rx_byte    = rx_byte_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_ps2_game_input.sv
// Testbench for ps2_game_input: directed scenarios followed by random
// scan-code traffic, checked against a key-state model of the keyboard
// protocol.
module tb_ps2_game_input;
    localparam int FL  = 8;
    localparam int TO  = 400;
    localparam int HP  = 30;   // PS/2 half period in system clocks
    localparam int GAP = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk, ps2_data;
    logic       ctrl_up, ctrl_down, ctrl_left, ctrl_right, shooting;
    logic       enter, bomb, rx_valid, frame_err;
    logic [7:0] rx_byte;

    ps2_game_input #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ctrl_up(ctrl_up), .ctrl_down(ctrl_down), .ctrl_left(ctrl_left),
        .ctrl_right(ctrl_right), .shooting(shooting), .enter(enter),
        .bomb(bomb), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Observed event counters and protocol-shape checks
    int n_valid = 0, n_err = 0, n_enter = 0, n_bomb = 0;
    int bad_width = 0, bad_lat = 0, err_cyc = 0;
    logic p_valid = 0, p_err = 0, p_enter = 0, p_bomb = 0, p_rst = 1;
    logic [4:0] p_lv = '0;

    always @(negedge clk) begin
        if (rx_valid)  n_valid++;
        if (frame_err) begin n_err++; err_cyc = cyc; end
        if (enter)     n_enter++;
        if (bomb)      n_bomb++;
        if (!reset && !p_rst) begin
            if ((rx_valid && p_valid) || (frame_err && p_err) ||
                (enter && p_enter) || (bomb && p_bomb)) bad_width++;
            if ((enter || bomb) && !p_valid) bad_lat++;
            if ({ctrl_up, ctrl_down, ctrl_left, ctrl_right, shooting} != p_lv && !p_valid)
                bad_lat++;
        end
        p_valid = rx_valid; p_err = frame_err; p_enter = enter; p_bomb = bomb;
        p_rst = reset;
        p_lv = {ctrl_up, ctrl_down, ctrl_left, ctrl_right, shooting};
    end

    // Reference model: key states and pending prefixes
    logic m_up, m_down, m_left, m_right, m_shoot, m_enter, m_x, m_ext, m_brk;
    logic [7:0] exp_byte;
    int exp_valid = 0, exp_err = 0, exp_enter = 0, exp_bomb = 0;
    int vectors = 0, miscompares = 0;
    int last_fall = 0;

    task automatic model_reset();
        {m_up, m_down, m_left, m_right, m_shoot, m_enter, m_x, m_ext, m_brk} = '0;
        exp_byte = 8'h00;
    endtask

    task automatic key_event(input logic ext, input logic [7:0] b, input logic mk);
        if (ext) begin
            if (b == 8'h75) m_up    = mk;
            if (b == 8'h72) m_down  = mk;
            if (b == 8'h6B) m_left  = mk;
            if (b == 8'h74) m_right = mk;
        end else begin
            if (b == 8'h1A) m_shoot = mk;
            if (b == 8'h5A) begin
                if (mk && !m_enter) exp_enter++;
                m_enter = mk;
            end
            if (b == 8'h22) begin
                if (mk && !m_x) exp_bomb++;
                m_x = mk;
            end
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_brk) begin
            key_event(m_ext, b, 1'b0);
            m_ext = 0; m_brk = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0 && !m_ext) begin
            m_ext = 1;
        end else begin
            key_event(m_ext, b, 1'b1);
            m_ext = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rx_byte"}, {24'd0, rx_byte}, {24'd0, exp_byte});
        chk({tag, ".n_valid"}, n_valid, exp_valid);
        chk({tag, ".n_err"},   n_err,   exp_err);
        chk({tag, ".n_enter"}, n_enter, exp_enter);
        chk({tag, ".n_bomb"},  n_bomb,  exp_bomb);
        chk({tag, ".levels"},
            {27'd0, ctrl_up, ctrl_down, ctrl_left, ctrl_right, shooting},
            {27'd0, m_up, m_down, m_left, m_right, m_shoot});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HP);
        ps2_clk = 1'b0;
        last_fall = cyc;
        wait_cyc(HP);
        ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input int fault);
        logic [10:0] f;
        f = {1'b1, ~(^b), b, 1'b0};
        if (fault == 1) f[9]  = ~f[9];
        if (fault == 2) f[10] = 1'b0;
        if (fault == 3) f[0]  = 1'b1;
        return f;
    endfunction

    // fault: 0 clean, 1 wrong parity, 2 bad stop, 3 bad start
    task automatic send_frame(input logic [7:0] b, input int fault, input string tag);
        logic [10:0] f;
        f = mk_frame(b, fault);
        for (int i = 0; i < 11; i++) send_bit(f[i]);
        wait_cyc(GAP);
        if (fault == 0) begin
            exp_valid++;
            exp_byte = b;
            model_byte(b);
        end else begin
            exp_err++;
        end
        check_all(tag);
    endtask

    task automatic do_reset();
        wait_cyc(1);
        #2 reset = 1'b1;
        #1;
        chk("reset_outputs",
            {18'd0, ctrl_up, ctrl_down, ctrl_left, ctrl_right, shooting, enter,
             bomb, rx_valid, frame_err, rx_byte == 8'h00}, 32'd1);
        model_reset();
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(4);
    endtask

    initial begin
        logic [7:0] pool [10];
        logic [10:0] f;
        int base, delta;

        pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1A, 8'h5A, 8'h22, 8'h00};
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        reset = 1'b1;
        model_reset();
        wait_cyc(5);
        chk("reset_state",
            {18'd0, ctrl_up, ctrl_down, ctrl_left, ctrl_right, shooting, enter,
             bomb, rx_valid, frame_err, rx_byte}, 32'd0);
        reset = 1'b0;
        wait_cyc(5);

        // Z press and release
        send_frame(8'h1A, 0, "z_make");
        send_frame(8'hF0, 0, "z_brk_f0");
        send_frame(8'h1A, 0, "z_brk");

        // Up arrow: extended make/break, then keypad code is ignored
        send_frame(8'hE0, 0, "up_e0");
        send_frame(8'h75, 0, "up_make");
        send_frame(8'hE0, 0, "up_b_e0");
        send_frame(8'hF0, 0, "up_b_f0");
        send_frame(8'h75, 0, "up_brk");
        send_frame(8'h75, 0, "keypad8");
        send_frame(8'h1A, 0, "idle_after_kp");
        send_frame(8'hF0, 0, "z2_f0");
        send_frame(8'h1A, 0, "z2_brk");

        // Enter typematic
        send_frame(8'h5A, 0, "ent1");
        send_frame(8'h5A, 0, "ent_rep1");
        send_frame(8'h5A, 0, "ent_rep2");
        send_frame(8'hF0, 0, "ent_f0");
        send_frame(8'h5A, 0, "ent_brk");
        send_frame(8'h5A, 0, "ent2");
        send_frame(8'hF0, 0, "ent2_f0");
        send_frame(8'h5A, 0, "ent2_brk");

        // Parity error then clean X
        send_frame(8'h22, 1, "x_parity");
        send_frame(8'h22, 0, "x_make");
        send_frame(8'hF0, 0, "x_f0");
        send_frame(8'h22, 0, "x_brk");

        // Timeout: start plus 4 data bits, then stall
        base = n_err;
        f = mk_frame(8'h22, 0);
        for (int i = 0; i < 5; i++) send_bit(f[i]);
        wait_cyc(TO + FL - 2 - HP - 5);
        chk("timeout_not_early", n_err, base);
        wait_cyc(200);
        chk("timeout_once", n_err, base + 1);
        delta = err_cyc - last_fall;
        chk("timeout_delay", {31'd0, (delta >= TO + FL + 1) && (delta <= TO + FL + 5)}, 32'd1);
        exp_err++;
        send_frame(8'h22, 0, "x_after_to");
        send_frame(8'hF0, 0, "x3_f0");
        send_frame(8'h22, 0, "x3_brk");

        // Glitch of FILTER_LEN-1 cycles must not be captured
        base = n_err;
        ps2_clk = 1'b0;
        wait_cyc(FL - 1);
        ps2_clk = 1'b1;
        wait_cyc(TO + 50);
        chk("glitch_no_err", n_err, base);
        send_frame(8'h1A, 0, "after_glitch");
        send_frame(8'hF0, 0, "g_f0");
        send_frame(8'h1A, 0, "g_brk");

        // Reset mid-frame with left held
        send_frame(8'hE0, 0, "left_e0");
        send_frame(8'h6B, 0, "left_make");
        f = mk_frame(8'h74, 0);
        for (int i = 0; i < 4; i++) send_bit(f[i]);
        do_reset();
        send_frame(8'hE0, 0, "left2_e0");
        send_frame(8'h6B, 0, "left2_make");
        send_frame(8'hE0, 0, "left2_b_e0");
        send_frame(8'hF0, 0, "left2_b_f0");
        send_frame(8'h6B, 0, "left2_brk");

        // Random traffic
        for (int n = 0; n < 25; n++) begin
            logic [7:0] b;
            int fault;
            b = pool[$urandom_range(0, 9)];
            if (b == 8'h00) b = 8'($urandom_range(0, 255));
            fault = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            send_frame(b, fault, "rand");
        end

        chk("pulse_width", bad_width, 0);
        chk("output_latency", bad_lat, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ps2_game_input.md
# ps2_game_input

PS/2 keyboard front end for the shooter game. It receives PS/2 Set-2 scan codes from the keyboard lines and decodes make/break sequences. It then drives the game control signals that the top level routes to the player, laser and FSM units: held-level arrows, held-level shooting, and single-cycle enter/bomb pulses. It sits directly upstream of the top-level control nets `ctrl_up/down/left/right`, `shooting`, `enter` and `bomb`.

## Interface
Parameters:
- `FILTER_LEN`, 8: consecutive stable system-clock cycles required before the filtered `ps2_clk` level changes.
- `TIMEOUT`, 200_000: cycles without a filtered falling edge, mid-frame, before the partial frame is aborted (2 ms at 100 MHz).

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `ps2_clk` in 1: raw keyboard clock, asynchronous.
- `ps2_data` in 1: raw keyboard data, asynchronous.
- `ctrl_up` out 1: Up arrow held.
- `ctrl_down` out 1: Down arrow held.
- `ctrl_left` out 1: Left arrow held.
- `ctrl_right` out 1: Right arrow held.
- `shooting` out 1: Z held.
- `enter` out 1: one-cycle pulse on first make of Enter.
- `bomb` out 1: one-cycle pulse on first make of X.
- `rx_byte` out 8: last good byte received.
- `rx_valid` out 1: one-cycle strobe when `rx_byte` updates.
- `frame_err` out 1: one-cycle pulse on parity, start, stop or timeout error.

## Operation
- **Input conditioning.** `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser. The synchronised `ps2_clk` feeds a stability filter. The filtered level changes only after the input differs from it for `FILTER_LEN` consecutive cycles. Filtered clock resets to 1.
- **Bit capture.**
  - On each filtered falling edge, the synchronised data is sampled into an 11-bit frame: start(0), D0..D7 LSB first, odd parity, stop(1).
  - The bit counter runs 0..10.
  - The frame is checked after bit 10. It is good iff start=0, stop=1 and XOR(D0..D7, parity)=1.
  - Good frame: `rx_byte`←data, `rx_valid` pulses.
  - Bad frame: `frame_err` pulses, `rx_byte` is unchanged, and the decoder sees nothing.
  - The counter returns to 0 in both cases.
- **Timeout.** A watchdog counter runs while the bit counter ≠ 0 and clears on every falling edge. On reaching `TIMEOUT`:
  - the bit counter goes to 0;
  - `frame_err` pulses once;
  - the watchdog stops until the next edge.
- **Decoder FSM**, advanced only on `rx_valid`:
  - States: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
  - IDLE: E0→EXT; F0→BRK; other byte → make(normal code), stay IDLE.
  - EXT: F0→EXT_BRK; other byte → make(extended code), go to IDLE.
  - BRK: any byte → break(normal code), go to IDLE.
  - EXT_BRK: any byte → break(extended code), go to IDLE.
- **Key map.** Make sets a key, break clears it. All other codes, and E0-prefixed variants of normal codes, are ignored.
  - Extended: 75=up, 72=down, 6B=left, 74=right.
  - Normal: 1A=Z (`shooting`), 5A=Enter, 22=X.
  - Unprefixed 75/72/6B/74 (keypad) are ignored.
- **Pulse outputs.** Internal held flags track Enter and X.
  - `enter` (resp. `bomb`) pulses only on a make while its flag is 0; the make then sets the flag.
  - Typematic repeats while held produce no pulse. Break clears the flag.
- **Opposing directions.** Opposing arrows held simultaneously are both output as 1; the player unit resolves them.
- **Ignored traffic.** Host-to-device traffic is not supported, and the lines are never driven. The E1 pause sequence decodes as ignored codes.

## Timing
- **Reset value.** Every output is 0. The FSM is IDLE, counters are 0, held flags are 0.
- **Frame latency.** Cycle N is the cycle the filtered falling edge of the stop bit is detected.
  - `rx_valid`/`rx_byte` or `frame_err` are asserted in N+1.
  - Level outputs update, and `enter`/`bomb` pulse, in N+2. Pulses last exactly one cycle.
- **Edge latency.** A raw `ps2_clk` fall reaches the edge detector 2+`FILTER_LEN` cycles later.
- **Reset mid-frame.** A partial frame is discarded and all held keys are released. Decoding resumes on the next complete frame after reset deasserts.
- **Simultaneous events.** If a timeout and a falling edge fall in the same cycle, the edge wins and no timeout is raised.

## Test plan
- **Z press and release.** Clean frame 0x1A at a 12.5 kHz PS/2 clock → `rx_byte`=0x1A, `rx_valid` high exactly one cycle, `shooting`=1 at N+2. Then F0,1A → `shooting`=0, no `frame_err`.
- **Up arrow, extended and keypad.** E0,75 → `ctrl_up`=1. E0,F0,75 → 0. Plain 75 (keypad) → `ctrl_up` stays 0 and FSM ends in IDLE.
- **Enter typematic.** 5A,5A,5A → `enter` pulses exactly once. F0,5A then 5A → a second single pulse.
- **Parity error.** 0x22 sent with even parity → `frame_err` one pulse, `rx_valid` never asserted, `bomb` stays 0. A following clean 0x22 → `bomb` one pulse.
- **Timeout.** Start plus 4 bits, then stall → `frame_err` pulses once, `TIMEOUT` cycles after the last edge. A following clean 0x22 decodes correctly.
- **Glitch and reset.**
  - A `ps2_clk` low glitch lasting `FILTER_LEN`-1 cycles → no bit captured.
  - With `ctrl_left` held, `reset` asserted mid-frame → all outputs 0 immediately.
  - A post-reset E0,6B → `ctrl_left`=1.
